// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative multiply/divide unit with HI/LO result registers
//
// Radix-2 shift-add multiplier and restoring divider sharing one iteration
// counter. One result bit per cycle, then a single sign-fix cycle.
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous reset, active low
//   start  in   1      request, sampled only when idle
//   op     in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   a      in   WIDTH  operand A / dividend / MTHI-MTLO data
//   b      in   WIDTH  operand B / divisor
//   flush  in   1      abort an in-flight operation
//   busy   out  1      operation in progress
//   done   out  1      one-cycle pulse after a mul/div result lands in HI/LO
//   dz     out  1      divide-by-zero flag of the last divide
//   hi     out  WIDTH  HI register
//   lo     out  WIDTH  LO register
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_q;     // negate product / quotient at fix
  logic               r_neg_r;     // negate remainder at fix
  logic               r_bzero;
  logic [WIDTH-1:0]   r_mcand;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   r_orig_a;    // raw dividend, returned in HI on divide by zero
  logic [2*WIDTH-1:0] r_acc;       // mul: product/multiplier; div: low half is dividend/quotient
  logic [WIDTH:0]     r_rem;
  logic               r_done;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_signed;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_trial;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // flush wins over start even when idle
  assign w_accept = (r_state == S_IDLE) && start && !flush;
  assign w_signed = ~op[0];
  assign w_a_mag  = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_mag  = (w_signed && b[WIDTH-1]) ? -b : b;

  // Multiply: add multiplicand into the upper half when the multiplier LSB is set,
  // then shift the whole accumulator right by one (carry enters the top bit).
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);

  // Divide: shift the next dividend bit into the remainder and trial-subtract.
  // A set MSB of the trial result means the subtraction went negative.
  assign w_rem_sh = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_mcand};
  assign w_ge     = ~w_trial[WIDTH];

  assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept && !op[2]) w_next = S_CALC;
      S_CALC: begin
        if (flush)                   w_next = S_IDLE;
        else if (r_cnt == LAST_ITER) w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bzero  <= 1'b0;
      r_mcand  <= '0;
      r_orig_a <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (!op[2]) begin
              r_cnt    <= '0;
              r_is_div <= op[1];
              r_neg_q  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              r_neg_r  <= w_signed && a[WIDTH-1];
              r_bzero  <= (b == '0);
              r_orig_a <= a;
              r_rem    <= '0;
              r_mcand  <= op[1] ? w_b_mag : w_a_mag;
              r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
            end else if (!op[1]) begin
              if (op[0]) r_lo <= a;
              else       r_hi <= a;
            end
          end
        end
        S_CALC: begin
          if (!flush) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_is_div) begin
              r_rem              <= w_ge ? w_trial : w_rem_sh;
              r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], w_ge};
            end else begin
              r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            end
          end
        end
        S_FIX: begin
          if (!flush) begin
            r_done <= 1'b1;
            if (!r_is_div) begin
              {r_hi, r_lo} <= w_prod_fix;
            end else if (r_bzero) begin
              r_hi <= r_orig_a;
              r_lo <= '1;
              r_dz <= 1'b1;
            end else begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
              r_dz <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign dz   = r_dz;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - self-checking bench for mdu_iter (WIDTH=32 and WIDTH=8)
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  logic        start8, flush8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  mdu_iter #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8), .flush(flush8),
    .busy(busy8), .done(done8), .dz(dz8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Reference: plain integer arithmetic on the architectural operands.
  task automatic ref_op(input logic [2:0] rop, input logic [31:0] ra, input logic [31:0] rb,
                        input logic dz_in, output logic [31:0] rh, output logic [31:0] rl,
                        output logic rdz);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = $signed(ra);
    sb = $signed(rb);
    rdz = dz_in;
    case (rop)
      3'd0: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      3'd1: begin p = 64'(ra) * 64'(rb); rh = p[63:32]; rl = p[31:0]; end
      default: begin
        if (rb == 0) begin
          rh = ra; rl = 32'hFFFF_FFFF; rdz = 1'b1;
        end else if (rop == 3'd2) begin
          sq = sa / sb; sr = sa % sb;
          rh = sr[31:0]; rl = sq[31:0]; rdz = 1'b0;
        end else begin
          rh = ra % rb; rl = ra / rb; rdz = 1'b0;
        end
      end
    endcase
  endtask

  // Issue one mul/div and wait for done; lat counts edges after the accept edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    bcnt = busy ? 1 : 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (busy) bcnt++;
      if (done) break;
    end
  endtask

  task automatic run_op8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         output int lat);
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(posedge clk);
    #1 start8 = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (done8) break;
    end
  endtask

  vec_t        vecs[12];
  logic [31:0] eh, el, ra, rb;
  logic        edz, model_dz, seen;
  logic [2:0]  rop;
  int          lat, bcnt;

  initial begin
    vecs[0]  = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2]  = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[3]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5]  = '{3'd3, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{3'd0, 32'd2,         32'd3,         32'd0,         32'd6,         1'b1};
    vecs[7]  = '{3'd3, 32'd9,         32'd3,         32'd0,         32'd3,         1'b0};
    vecs[8]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[9]  = '{3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[10] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1};
    vecs[11] = '{3'd1, 32'h8000_0000, 32'd2,         32'h0000_0001, 32'h0000_0000, 1'b1};

    rst = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; flush8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dz",   dz,   0);
    chk("reset_hi",   hi,   0);
    chk("reset_lo",   lo,   0);
    rst = 1'b1;
    model_dz = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
      chk($sformatf("vec%0d_dz", i), dz, vecs[i].dz);
      chk($sformatf("vec%0d_lat", i), lat, 33);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, 33);
      model_dz = vecs[i].dz;
    end
    eh = vecs[11].hi;
    el = vecs[11].lo;

    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      ref_op(rop, ra, rb, model_dz, eh, el, edz);
      model_dz = edz;
      run_op(rop, ra, rb, lat, bcnt);
      chk($sformatf("rnd%0d_op%0d_hi", i, rop), hi, eh);
      chk($sformatf("rnd%0d_op%0d_lo", i, rop), lo, el);
      chk($sformatf("rnd%0d_dz", i), dz, edz);
      chk($sformatf("rnd%0d_lat", i), lat, 33);
    end

    // MTLO while idle
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'h5A5A_5A5A;
    @(posedge clk);
    #1 start = 1'b0;
    chk("mtlo_lo", lo, 32'h5A5A_5A5A);
    chk("mtlo_hi_kept", hi, eh);
    chk("mtlo_no_busy", busy, 0);
    chk("mtlo_no_done", done, 0);
    el = 32'h5A5A_5A5A;

    // MTHI while busy is ignored
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hA5A5_A5A5;
    @(posedge clk);
    #1 start = 1'b0;
    chk("mthi_busy_hi_kept", hi, eh);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
    end
    chk("mthi_busy_done", done, 1);
    chk("mthi_busy_mul_hi", hi, 32'd0);
    chk("mthi_busy_mul_lo", lo, 32'd12);
    eh = 32'd0;
    el = 32'd12;

    // flush at cycle 10 together with a new start
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; start = 1'b1; op = 3'd3; a = 32'd50; b = 32'd5;
    @(posedge clk);
    #1;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    flush = 1'b0; start = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (busy || done) seen = 1'b1;
    end
    chk("flush_no_activity", seen, 0);
    chk("flush_hi_kept", hi, eh);
    chk("flush_lo_kept", lo, el);

    // async reset mid-CALC clears everything without a clock edge
    run_op(3'd3, 32'h0000_1234, 32'd0, lat, bcnt);
    chk("pre_reset_dz", dz, 1);
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_hi",   hi,   0);
    chk("async_rst_lo",   lo,   0);
    chk("async_rst_dz",   dz,   0);
    @(negedge clk);
    rst = 1'b1;
    run_op(3'd0, 32'd3, 32'd5, lat, bcnt);
    chk("post_rst_lo",  lo, 32'd15);
    chk("post_rst_lat", lat, 33);

    // WIDTH=8 instance
    run_op8(3'd0, 8'hFD, 8'h05, lat);
    chk("w8_mult_hi",  hi8, 8'hFF);
    chk("w8_mult_lo",  lo8, 8'hF1);
    chk("w8_mult_lat", lat, 9);
    run_op8(3'd2, 8'h80, 8'hFF, lat);
    chk("w8_ovf_hi", hi8, 8'h00);
    chk("w8_ovf_lo", lo8, 8'h80);
    run_op8(3'd3, 8'h21, 8'h00, lat);
    chk("w8_dz_hi", hi8, 8'h21);
    chk("w8_dz_lo", lo8, 8'hFF);
    chk("w8_dz",    dz8, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Parametrised iterative multiply/divide unit with HI/LO result registers. It is the next-generation arithmetic companion to the multicycle CPU datapath and adds MULT/MULTU/DIV/DIVU/MTHI/MTLO support. It uses a radix-2 shift-add multiplier and a restoring divider that share one iteration counter. The unit has a start/busy/done handshake so the controller FSM can stall on mfhi/mflo, plus a flush input for exception abort.

Parameters:
WIDTH, 32, operand and HI/LO width; must be even and >= 4.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk    in   1        clock, all state updates on rising edge
rst    in   1        reset, asynchronous, active-low (0 = reset)
start  in   1        request; sampled only when busy=0
op     in   3        000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (no-op)
a      in   WIDTH    operand A / dividend / MTHI-MTLO data
b      in   WIDTH    operand B / divisor
flush  in   1        synchronous abort of an in-flight operation
busy   out  1        operation in progress
done   out  1        one-cycle pulse when HI/LO have been updated by mul/div
dz     out  1        sticky divide-by-zero flag for the last divide
hi     out  WIDTH    HI register
lo     out  WIDTH    LO register

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, dz, hi, lo, counter and internal regs all 0. Reset asserted mid-operation discards the operation.
- FSM states: IDLE, CALC, FIX.
- IDLE + start + op in {MULT, MULTU, DIV, DIVU}: latch |a|, |b| (magnitudes for signed ops, raw for unsigned), result signs and op; counter=0; go to CALC. busy=1 from the next cycle.
- IDLE + start + MTHI/MTLO: hi<=a or lo<=a at that edge. No busy, no done, dz unchanged.
- Reserved op: ignored.
- CALC: one iteration per cycle, WIDTH iterations (counter 0..WIDTH-1), then go to FIX.
  - Multiply: 2*WIDTH-bit product shift-add, one multiplier bit per cycle.
  - Divide: restoring divide, one quotient bit per cycle. Remainder register is WIDTH+1 bits.
- FIX (1 cycle): apply sign correction, write hi/lo, done<=1 for exactly one cycle, busy<=0, return to IDLE.
- Latency: accept edge E. hi/lo are updated and done=1 after edge E+WIDTH+1. busy is high for cycles E+1..E+WIDTH+1 and is low in the done cycle.
- Signed multiply: product is negated when sign(a) != sign(b). hi = upper WIDTH bits, lo = lower WIDTH bits. MULTU uses no correction.
- Signed divide: quotient is negative when signs differ. Remainder takes the sign of the dividend (truncating division). lo = quotient, hi = remainder.
- Divide by zero (b==0): still takes the full latency. Result is lo = all ones, hi = a (original dividend), dz=1. Any divide with b!=0 clears dz at FIX. Multiplies leave dz unchanged.
- Signed overflow (a = -2^(WIDTH-1), b = -1): lo = -2^(WIDTH-1) (0x80000000 for WIDTH=32), hi = 0, dz=0.
- start while busy=1: ignored, including MTHI/MTLO. There is no queueing, and the requester must hold start until busy=0.
- flush=1 in CALC or FIX: return to IDLE next edge. hi/lo/dz unchanged, no done, busy=0.
- flush in IDLE: no effect. flush has priority over start in the same cycle.
- A start in the done cycle (busy=0) is accepted normally, so back-to-back operations are allowed.
- hi/lo change only at FIX, at MTHI/MTLO, or at reset.

Test Plan:
- WIDTH=32. Reset, then MULT a=0xFFFFFFFD (-3), b=5 -> done pulses 33 cycles after the accept edge; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then DIVU a=100, b=7 -> lo=14, hi=2, dz=0.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, dz=1. Then a MULT leaves dz=1. Then DIVU 9/3 -> lo=3, hi=0, dz=0.
- Start DIV, assert flush at cycle 10 together with a new start -> busy=0 next cycle, no done, hi/lo keep prior values, the new start is not accepted. Also: MTHI 0xA5A5A5A5 while busy -> ignored; MTLO 0x5A5A5A5A while idle -> lo=0x5A5A5A5A next cycle.
- Drive rst=0 asynchronously mid-CALC -> busy, done, hi, lo, dz all 0 immediately. Re-run with WIDTH=8: MULT -3*5 -> hi=0xFF, lo=0xF1, done 9 cycles after the accept edge.
